// File: rtl/hc138_scan_seq.sv
// rtl/hc138_scan_seq.sv - timed channel scan sequencer driving a 74HC138-style 3-to-8 decoder
// Optional channel mask: define HC138_SCAN_MASK_EN to add the ch_mask input.
module hc138_scan_seq #(
  parameter int DWELL_W      = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [DWELL_W-1:0] dwell,
`ifdef HC138_SCAN_MASK_EN
  input  logic [7:0]         ch_mask,
`endif
  output logic [2:0]         addr,
  output logic               e1_n,
  output logic               e2_n,
  output logic               e3,
  output logic               busy,
  output logic               ch_strobe,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  localparam logic [DWELL_W-1:0] BLANK_LOAD =
    DWELL_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  // Lowest channel enabled in a mask (0 when the mask is empty).
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest_set = 3'(i);
  endfunction

  // Whether any enabled channel lies above the current one.
  function automatic logic any_above(input logic [7:0] m, input logic [2:0] a);
    any_above = 1'b0;
    for (int i = 0; i < 8; i++) if (m[i] && (i > int'(a))) any_above = 1'b1;
  endfunction

  // Next enabled channel above the current one; masked channels cost no cycles.
  function automatic logic [2:0] next_above(input logic [7:0] m, input logic [2:0] a);
    next_above = a;
    for (int i = 7; i >= 0; i--) if (m[i] && (i > int'(a))) next_above = 3'(i);
  endfunction

  state_t             state_q, state_d;
  logic [2:0]         chan_q, chan_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;
  logic               pend_q, pend_d;
  logic               fin_q, fin_d;
  logic [7:0]         run_mask, new_mask;
  logic [DWELL_W-1:0] dwell_src, drive_load;
  logic               enter_ch;

  logic [2:0] addr_q, addr_d;
  logic       e1_n_q, e1_n_d, e2_n_q, e2_n_d, e3_q, e3_d;
  logic       busy_q, busy_d, ch_strobe_q, ch_strobe_d, done_q, done_d;

`ifdef HC138_SCAN_MASK_EN
  logic [7:0] mask_q, mask_d;
  assign run_mask = mask_q;
  assign new_mask = ch_mask;
`else
  assign run_mask = 8'hFF;
  assign new_mask = 8'hFF;
`endif

  // In IDLE the dwell input is about to be latched, so load from it directly.
  assign dwell_src  = (state_q == S_IDLE) ? dwell : dwell_q;
  assign drive_load = (dwell_src == '0) ? '0 : dwell_src - 1'b1;

  // State register plus latched scan configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      chan_q  <= 3'd0;
      cnt_q   <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      pend_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef HC138_SCAN_MASK_EN
      mask_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      pend_q  <= pend_d;
      fin_q   <= fin_d;
`ifdef HC138_SCAN_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // Next-state logic: channel advance, dwell/blank countdown and stop handling.
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    cont_d   = cont_q;
    pend_d   = pend_q;
    fin_d    = 1'b0;
    enter_ch = 1'b0;
`ifdef HC138_SCAN_MASK_EN
    mask_d   = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && (new_mask != 8'h00)) begin
          dwell_d  = dwell;
          cont_d   = mode_cont;
`ifdef HC138_SCAN_MASK_EN
          mask_d   = ch_mask;
`endif
          chan_d   = lowest_set(new_mask);
          enter_ch = 1'b1;
        end
      end
      S_BLANK: begin
        if (stop) pend_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DRIVE;
          cnt_d   = drive_load;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRIVE: begin
        if (stop) pend_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pend_q) begin
          state_d = S_IDLE;
          fin_d   = 1'b1;
          pend_d  = 1'b0;
        end else if (any_above(run_mask, chan_q)) begin
          chan_d   = next_above(run_mask, chan_q);
          enter_ch = 1'b1;
        end else if (cont_q) begin
          chan_d   = lowest_set(run_mask);
          enter_ch = 1'b1;
        end else begin
          state_d = S_IDLE;
          fin_d   = 1'b1;
          pend_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_ch) begin
      if (BLANK_CYCLES == 0) begin
        state_d = S_DRIVE;
        cnt_d   = drive_load;
      end else begin
        state_d = S_BLANK;
        cnt_d   = BLANK_LOAD;
      end
    end
  end

  // Output decode: decoder enabled only in DRIVE; strobe on the first DRIVE cycle.
  always_comb begin
    addr_d      = chan_q;
    e1_n_d      = 1'b1;
    e2_n_d      = 1'b1;
    e3_d        = 1'b0;
    busy_d      = (state_q != S_IDLE);
    ch_strobe_d = 1'b0;
    done_d      = fin_q;
    if (state_q == S_DRIVE) begin
      e1_n_d      = 1'b0;
      e2_n_d      = 1'b0;
      e3_d        = 1'b1;
      ch_strobe_d = (cnt_q == drive_load);
    end
  end

  // Registered outputs so the decoder pins never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= 3'd0;
      e1_n_q      <= 1'b1;
      e2_n_q      <= 1'b1;
      e3_q        <= 1'b0;
      busy_q      <= 1'b0;
      ch_strobe_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      e1_n_q      <= e1_n_d;
      e2_n_q      <= e2_n_d;
      e3_q        <= e3_d;
      busy_q      <= busy_d;
      ch_strobe_q <= ch_strobe_d;
      done_q      <= done_d;
    end
  end

  assign addr      = addr_q;
  assign e1_n      = e1_n_q;
  assign e2_n      = e2_n_q;
  assign e3        = e3_q;
  assign busy      = busy_q;
  assign ch_strobe = ch_strobe_q;
  assign done      = done_q;

endmodule

// File: tb/tb_hc138_scan_seq.sv
// tb/tb_hc138_scan_seq.sv - self-checking bench for hc138_scan_seq (frame-queue reference model)
module tb_hc138_scan_seq;
  localparam int DW = 16;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode_cont = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [7:0]    ch_mask = 8'hFF;
  logic [2:0]    addr;
  logic          e1_n, e2_n, e3, busy, ch_strobe, done;

  always #5 clk = ~clk;

  hc138_scan_seq #(.DWELL_W(DW), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_cont(mode_cont),
    .dwell(dwell),
`ifdef HC138_SCAN_MASK_EN
    .ch_mask(ch_mask),
`endif
    .addr(addr), .e1_n(e1_n), .e2_n(e2_n), .e3(e3), .busy(busy),
    .ch_strobe(ch_strobe), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a list of per-cycle frames (blanking, then dwell).
  typedef struct packed {
    logic [2:0] a;
    logic       en;
    logic       stb;
    logic       bsy;
    logic       dn;
    logic       last;
  } frame_t;

  frame_t     cur, expo;
  frame_t     q[$];
  int         m_dwell;
  bit         m_cont, m_pend;
  logic [7:0] m_mask;

  function automatic frame_t mk(input int a, input bit en, input bit stb, input bit bsy,
                                input bit dn, input bit last);
    frame_t f;
    f.a = 3'(a); f.en = en; f.stb = stb; f.bsy = bsy; f.dn = dn; f.last = last;
    return f;
  endfunction

  function automatic int low_bit(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_bit(input logic [7:0] m, input int a);
    for (int i = a + 1; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic build(input int a);
    int d;
    q.delete();
    for (int i = 0; i < BC; i++) q.push_back(mk(a, 0, 0, 1, 0, 0));
    d = (m_dwell == 0) ? 1 : m_dwell;
    for (int i = 0; i < d; i++) q.push_back(mk(a, 1, i == 0, 1, 0, i == d - 1));
  endtask

  task automatic model_step();
    frame_t prev;
    bit     pend_old;
    int     nb;
    prev = cur;
    if (!cur.bsy) begin
      if (start && ch_mask != 8'h00) begin
        m_dwell = int'(dwell); m_cont = mode_cont; m_mask = ch_mask;
        build(low_bit(ch_mask));
        cur = q.pop_front();
      end else begin
        cur = mk(int'(cur.a), 0, 0, 0, 0, 0);
      end
    end else begin
      pend_old = m_pend;
      if (stop) m_pend = 1'b1;
      if (!cur.last) begin
        cur = q.pop_front();
      end else begin
        nb = next_bit(m_mask, int'(cur.a));
        if (pend_old || (nb < 0 && !m_cont)) begin
          cur = mk(int'(cur.a), 0, 0, 0, 1, 0);
          m_pend = 1'b0;
        end else begin
          build((nb < 0) ? low_bit(m_mask) : nb);
          cur = q.pop_front();
        end
      end
    end
    // Outputs are registered, so what shows after this edge is the frame before it.
    expo = prev;
  endtask

  // Model process: advances on every clock edge, resets asynchronously.
  initial begin
    cur = mk(0, 0, 0, 0, 0, 0); expo = cur; m_pend = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cur = mk(0, 0, 0, 0, 0, 0); expo = cur; m_pend = 1'b0; q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Compare process: every output against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("addr", addr, expo.a);
      check("e1_n", e1_n, !expo.en);
      check("e2_n", e2_n, !expo.en);
      check("e3", e3, expo.en);
      check("busy", busy, expo.bsy);
      check("ch_strobe", ch_strobe, expo.stb);
      check("done", done, expo.dn);
    end
  end

  int stb_seq[$];

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs from the current negedge (k=0) until done, collecting strobes and drive cycles.
  task automatic wait_done(input int budget, input int poke_at,
                           output int lat, output int nstb, output int ndrv);
    lat = -1; nstb = 0; ndrv = 0; stb_seq.delete();
    for (int k = 0; k < budget; k++) begin
      if (k > 0) @(negedge clk);
      if (k == poke_at) begin start = 1'b1; dwell = 7; end else start = 1'b0;
      if (ch_strobe) begin nstb++; stb_seq.push_back(int'(addr)); end
      if (e3) ndrv++;
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  int lat, nstb, ndrv, cnt_a, cnt_b, cnt_c;
  bit seen;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_addr", addr, 0); check("rst_e1_n", e1_n, 1); check("rst_e2_n", e2_n, 1);
    check("rst_e3", e3, 0); check("rst_busy", busy, 0); check("rst_strobe", ch_strobe, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single shot, dwell=3: done 8*(2+3)+1 cycles after start is sampled
    dwell = 3; mode_cont = 1'b0;
    pulse_start();
    wait_done(200, -1, lat, nstb, ndrv);
    check("t1_latency", lat, 41); check("t1_strobes", nstb, 8); check("t1_drive_cycles", ndrv, 24);
    for (int i = 0; i < stb_seq.size(); i++) check("t1_addr_order", stb_seq[i], i);
    @(negedge clk);
    check("t1_busy_after", busy, 0);

    // Continuous wrap, dwell=1: 3 passes with no done
    dwell = 1; mode_cont = 1'b1;
    pulse_start();
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < 75; k++) begin
      if (k > 0) @(negedge clk);
      if (ch_strobe) cnt_a++;
      if (done) cnt_b++;
      if (k >= 1 && !busy) cnt_c++;
    end
    check("t2_strobes", cnt_a, 24); check("t2_no_done", cnt_b, 0); check("t2_busy_drops", cnt_c, 0);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_done(100, -1, lat, nstb, ndrv);

    // Graceful stop during the blanking of channel 4
    repeat (2) @(negedge clk);
    dwell = 3; mode_cont = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (addr == 3'd4 && busy && !e3) seen = 1'b1;
    end
    check("t3_blank4_seen", seen, 1);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_done(100, -1, lat, nstb, ndrv);
    check("t3_drive_cycles", ndrv, 3); check("t3_strobes", nstb, 1);
    check("t3_addr_held", addr, 4); check("t3_e1_n", e1_n, 1); check("t3_e3", e3, 0);
    @(negedge clk);
    check("t3_busy_after", busy, 0);

    // dwell=0 as 1, start+stop together in IDLE, start while busy ignored
    dwell = 0; mode_cont = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    wait_done(200, 6, lat, nstb, ndrv);
    check("t4_latency", lat, 25); check("t4_strobes", nstb, 8); check("t4_drive_cycles", ndrv, 8);
    repeat (2) @(negedge clk);
    check("t4_no_restart", busy, 0);

    // Asynchronous reset during DRIVE
    dwell = 4; mode_cont = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (e3) seen = 1'b1;
    end
    check("t5_drive_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_e1_n", e1_n, 1); check("t5_e2_n", e2_n, 1); check("t5_e3", e3, 0);
    check("t5_busy", busy, 0); check("t5_addr", addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dwell = 2; mode_cont = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_done(200, -1, lat, nstb, ndrv);
    check("t5_latency", lat, 33); check("t5_strobes", nstb, 8);

`ifdef HC138_SCAN_MASK_EN
    // Masked scan: only channels 2, 5, 7
    repeat (2) @(negedge clk);
    ch_mask = 8'b1010_0100; dwell = 1; mode_cont = 1'b0;
    pulse_start();
    wait_done(100, -1, lat, nstb, ndrv);
    check("m_latency", lat, 10); check("m_strobes", nstb, 3);
    if (stb_seq.size() == 3) begin
      check("m_ch0", stb_seq[0], 2); check("m_ch1", stb_seq[1], 5); check("m_ch2", stb_seq[2], 7);
    end
    ch_mask = 8'h00;
    @(negedge clk);
    pulse_start();
    cnt_a = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy || done) cnt_a++;
    end
    check("m_empty_ignored", cnt_a, 0);
    ch_mask = 8'hFF;
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = ($urandom_range(24) == 0);
      stop = ($urandom_range(69) == 0);
      dwell = DW'($urandom_range(4));
      mode_cont = $urandom_range(1);
`ifdef HC138_SCAN_MASK_EN
      ch_mask = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
`endif
    end
    start = 1'b0; stop = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    stop = 1'b0;
    check("rand_drain_idle", seen, 1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hc138_scan_seq.md
Name: hc138_scan_seq

Overview:
- Timed address sequencer placed directly upstream of the 3-to-8 decoder (encoder_138).
- Drives the decoder's 3-bit select and its three enables (E1 active-low, E2 active-low, E3 active-high). Steps through channels 0..7 with a programmable dwell time per channel.
- Inserts blanking cycles between channels, with the decoder disabled, so the select never changes while the decoder is enabled.
- Supports single-shot and continuous scan, and a graceful stop.

Parameters:
- DWELL_W, 16: width of the dwell-count input.
- BLANK_CYCLES, 2: decoder-disabled cycles before each channel; 0 means no blanking.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a scan; only honoured in IDLE.
- stop  input  1  request to end a scan after the current channel completes.
- mode_cont  input  1  1 = wrap 7->0 continuously; 0 = one pass. Latched at accepted start.
- dwell  input  DWELL_W  enabled cycles per channel. Latched at accepted start. 0 is treated as 1.
- addr  output  3  decoder select (DataIn).
- e1_n  output  1  decoder E1.
- e2_n  output  1  decoder E2.
- e3  output  1  decoder E3.
- busy  output  1  high whenever the FSM is not in IDLE.
- ch_strobe  output  1  one-cycle pulse on the first DRIVE cycle of each channel.
- done  output  1  one-cycle pulse on the cycle the FSM returns to IDLE.

Behaviour:
- Reset (asynchronous, immediate, also mid-scan): FSM=IDLE, addr=0, e1_n=1, e2_n=1, e3=0, busy=0, ch_strobe=0, done=0, stop_pend=0.
- Enable encoding:
  - DRIVE: e1_n=0, e2_n=0, e3=1.
  - Every other state: e1_n=1, e2_n=1, e3=0.
  - All enable outputs are registered.
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - start=1 -> latch dwell/mode_cont, addr=0, busy=1.
  - Next state is BLANK, or DRIVE directly if BLANK_CYCLES=0.
  - start and stop asserted together in IDLE: start accepted, stop ignored.
- BLANK: lasts exactly BLANK_CYCLES cycles, decoder disabled, addr stable. Then -> DRIVE.
- DRIVE: lasts exactly max(dwell,1) cycles; ch_strobe asserts on its first cycle.
- On the last DRIVE cycle, the next state is chosen in this order:
  - stop_pend=1 -> IDLE, done pulse, stop_pend cleared, addr held.
  - addr<7 -> addr+1, BLANK (or DRIVE if BLANK_CYCLES=0).
  - addr=7 and mode_cont=1 -> addr wraps to 0, BLANK.
  - addr=7 and mode_cont=0 -> IDLE, done pulse.
- stop:
  - Sampled every busy cycle into stop_pend.
  - The current channel always finishes its full dwell; stop received during BLANK still allows that channel's DRIVE.
  - stop in IDLE has no effect.
- start while busy: ignored, with no effect on dwell/mode latches.
- addr changes only on the BLANK/DRIVE boundary while the decoder is disabled, or on the DRIVE->DRIVE transition when BLANK_CYCLES=0.
- Single-shot scan latency, start to done: 8*(BLANK_CYCLES+max(dwell,1)) cycles after start is sampled, plus one.
- Dwell counter: DWELL_W bits, counts down, no overflow possible.

Optional Feature:
- Macro: HC138_SCAN_MASK_EN.
- When defined:
  - Adds input ch_mask[7:0], latched at accepted start.
  - Channels whose mask bit is 0 are skipped with zero cycles: the next addr is the next set bit above the current one, wrapping only in continuous mode. The first channel is the lowest set bit.
  - Pass end is reached after the highest set bit.
  - ch_mask=0 at start: start ignored, busy stays 0, no done.
- When undefined: no ch_mask port; all 8 channels are scanned; behaviour exactly as above.

Test Plan:
- Reset, then single shot:
  - Stimulus: release rst_n; dwell=3, BLANK_CYCLES=2, mode_cont=0, start pulse.
  - Required: addr 0..7 in order, each with 2 disabled cycles then 3 cycles of e1_n=0/e2_n=0/e3=1.
  - Required: 8 ch_strobe pulses; done exactly 41 cycles after start is sampled; busy low afterwards.
- Continuous wrap:
  - Stimulus: mode_cont=1, dwell=1.
  - Required: after addr=7 DRIVE, addr=0 with blanking; no done pulse; busy stays 1 for 3 passes.
- Graceful stop:
  - Stimulus: assert stop during the BLANK of addr=4.
  - Required: addr=4 still drives its full dwell; done follows; FSM returns to IDLE with addr=4 and enables disabled.
- Edge inputs:
  - Stimulus: dwell=0; start pulsed while busy; start+stop in IDLE.
  - Required: dwell=0 gives 1-cycle DRIVE; mid-scan start causes no restart; start+stop in IDLE starts a full scan.
- Async reset mid-DRIVE:
  - Stimulus: drop rst_n asynchronously during a DRIVE.
  - Required: e1_n=1, e3=0, busy=0 immediately, before the next clock edge; a clean scan runs after release.
- HC138_SCAN_MASK_EN:
  - Stimulus: ch_mask=8'b1010_0100, single shot.
  - Required: only addr 2, 5, 7 driven, then done.
  - Stimulus: ch_mask=0.
  - Required: start ignored.
